// File: rtl/core_isa_pkg.sv
// core_isa_pkg: instruction word layout, opcode constants, fetch state encoding
// Contents: MASK_LSB/OPCODE_W field layout, opcode constants, has_operand(), fetch_state_t.
package core_isa_pkg;
    localparam int MASK_LSB = 12;
    localparam int OPCODE_W = 12;
    localparam logic [OPCODE_W-1:0] OP_LOADA = 12'd3;
    localparam logic [OPCODE_W-1:0] OP_JUMPZ = 12'd9;
    localparam logic [OPCODE_W-1:0] OP_JUMPN = 12'd13;
    localparam logic [OPCODE_W-1:0] OP_NOP   = 12'd47;
    localparam logic [OPCODE_W-1:0] OP_ENDOP = 12'd48;
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_OADDR, S_ODATA, S_PRES, S_HALT
    } fetch_state_t;
    function automatic logic has_operand(input logic [OPCODE_W-1:0] op);
        return op == OP_LOADA || op == OP_JUMPZ || op == OP_JUMPN;
    endfunction
endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational decode of a fetched word for one core
// Ports: instr_data in; mask_hit, opcode, has_operand, is_jump, is_end out.
module fetch_predecode
    import core_isa_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int DATA_W  = 16
) (
    input  logic [DATA_W-1:0]   instr_data,
    output logic                mask_hit,
    output logic [OPCODE_W-1:0] opcode,
    output logic                has_operand,
    output logic                is_jump,
    output logic                is_end
);
    // Whole mask nibble is ANDed with this core's one-hot select.
    assign mask_hit    = |(instr_data[MASK_LSB +: 4] & (4'b0001 << CORE_ID));
    assign opcode      = instr_data[OPCODE_W-1:0];
    assign has_operand = core_isa_pkg::has_operand(opcode);
    assign is_jump     = opcode == OP_JUMPZ || opcode == OP_JUMPN;
    assign is_end      = opcode == OP_ENDOP;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: per-core instruction fetch sequencer with mask filtering and operand assembly
// Ports: clock/reset/start control; instr_addr/instr_data memory port (1-cycle latency);
// instr_valid/instr_ready/instr_opcode/instr_operand/instr_has_operand presentation;
// branch_taken redirect qualifier; busy/halted status.
// Optional macro IFU_SKIP_COUNT_EN adds skip_count (saturating count of skipped words).
module instr_fetch_unit
    import core_isa_pkg::*;
#(
    parameter int CORE_ID  = 0,
    parameter int RESET_PC = 0,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [ADDR_W-1:0]   instr_addr,
    input  logic [DATA_W-1:0]   instr_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [OPCODE_W-1:0] instr_opcode,
    output logic [DATA_W-1:0]   instr_operand,
    output logic                instr_has_operand,
    input  logic                branch_taken,
    output logic                busy,
    output logic                halted
`ifdef IFU_SKIP_COUNT_EN
    ,
    output logic [15:0]         skip_count
`endif
);
    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic                mask_hit, pd_has, pd_jump, pd_end, jump_r, end_r;
    logic [OPCODE_W-1:0] pd_opcode;

    assign instr_addr = pc;

    fetch_predecode #(.CORE_ID(CORE_ID), .DATA_W(DATA_W)) u_predecode (
        .instr_data (instr_data),
        .mask_hit   (mask_hit),
        .opcode     (pd_opcode),
        .has_operand(pd_has),
        .is_jump    (pd_jump),
        .is_end     (pd_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            pc                <= ADDR_W'(RESET_PC);
            instr_valid       <= 1'b0;
            instr_opcode      <= '0;
            instr_operand     <= '0;
            instr_has_operand <= 1'b0;
            jump_r            <= 1'b0;
            end_r             <= 1'b0;
            busy              <= 1'b0;
            halted            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_ADDR;
                    pc    <= ADDR_W'(RESET_PC);
                    busy  <= 1'b1;
                end
                S_ADDR: state <= S_DATA;
                S_DATA: begin
                    // A skipped operand-bearing instruction also steps over its operand word.
                    pc <= pc + ADDR_W'((!mask_hit && pd_has) ? 2 : 1);
                    if (!mask_hit) begin
                        state <= S_ADDR;
                    end else begin
                        instr_opcode      <= pd_opcode;
                        instr_has_operand <= pd_has;
                        instr_operand     <= '0;
                        jump_r            <= pd_jump;
                        end_r             <= pd_end;
                        state             <= pd_has ? S_OADDR : S_PRES;
                        instr_valid       <= !pd_has;
                    end
                end
                S_OADDR: state <= S_ODATA;
                S_ODATA: begin
                    instr_operand <= instr_data;
                    pc            <= pc + ADDR_W'(1);
                    state         <= S_PRES;
                    instr_valid   <= 1'b1;
                end
                S_PRES: if (instr_ready) begin
                    instr_valid <= 1'b0;
                    if (end_r) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        if (jump_r && branch_taken) pc <= ADDR_W'(instr_operand);
                        state <= S_ADDR;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFU_SKIP_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset || (state == S_IDLE && start)) skip_count <= '0;
        else if (state == S_DATA && !mask_hit && skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: four fetch units on a shared memory, checked against a scan-ahead reference model
module tb_instr_fetch_unit;
    logic        clock = 0, reset = 1, start = 0;
    logic        ready [4], bt [4];
    logic [15:0] addr [4], data [4], opnd [4];
    logic [11:0] op [4];
    logic        dv [4], has [4], busy [4], halted [4];
`ifdef IFU_SKIP_COUNT_EN
    logic [15:0] skc [4];
`endif
    logic [15:0] mem [65536];
    int          tests = 0, fails = 0;
    bit          chk_en = 0;

    // Reference model: fetch-ahead position, cycles until presentation, presented fields.
    logic [15:0] m_pc [4], m_opnd [4], m_skip [4];
    logic [11:0] m_op [4];
    bit          m_busy [4], m_halt [4], m_valid [4], m_has [4];
    int          m_wait [4];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_core
        instr_fetch_unit #(.CORE_ID(g), .RESET_PC(0), .ADDR_W(16), .DATA_W(16)) dut (
            .clock            (clock),
            .reset            (reset),
            .start            (start),
            .instr_addr       (addr[g]),
            .instr_data       (data[g]),
            .instr_valid      (dv[g]),
            .instr_ready      (ready[g]),
            .instr_opcode     (op[g]),
            .instr_operand    (opnd[g]),
            .instr_has_operand(has[g]),
            .branch_taken     (bt[g]),
            .busy             (busy[g]),
            .halted           (halted[g])
`ifdef IFU_SKIP_COUNT_EN
            ,
            .skip_count       (skc[g])
`endif
        );
    end

    always @(posedge clock) for (int c = 0; c < 4; c++) data[c] <= mem[addr[c]];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Find the next word this core will present: each skipped word costs 2 cycles,
    // a presented one 2 (plus 2 more for its operand) before valid rises.
    task automatic launch(input int c);
        logic [15:0] p, q, wd;
        bit          h;
        int          w;
        p = m_pc[c];
        w = 0;
        for (int n = 0; n < 4096; n++) begin
            wd = mem[p];
            h  = wd[11:0] == 12'd3 || wd[11:0] == 12'd9 || wd[11:0] == 12'd13;
            q  = p + 16'd1;
            if (!wd[12+c]) begin
                w += 2;
                if (m_skip[c] != 16'hFFFF) m_skip[c]++;
                p += h ? 16'd2 : 16'd1;
            end else begin
                m_op[c]   = wd[11:0];
                m_has[c]  = h;
                m_opnd[c] = h ? mem[q] : 16'd0;
                m_pc[c]   = p + (h ? 16'd2 : 16'd1);
                m_wait[c] = w + (h ? 4 : 2);
                return;
            end
        end
        m_pc[c]   = p;
        m_wait[c] = 1 << 30;
    endtask

    always @(posedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (reset) begin
                m_busy[c] = 0; m_halt[c] = 0; m_valid[c] = 0; m_pc[c] = 0; m_skip[c] = 0;
            end else if (!m_busy[c] && !m_halt[c]) begin
                if (start) begin
                    m_busy[c] = 1; m_skip[c] = 0; m_pc[c] = 0;
                    launch(c);
                end
            end else if (m_busy[c]) begin
                if (m_valid[c]) begin
                    if (ready[c]) begin
                        m_valid[c] = 0;
                        if (m_op[c] == 12'd48) begin
                            m_busy[c] = 0; m_halt[c] = 1;
                        end else begin
                            if ((m_op[c] == 12'd9 || m_op[c] == 12'd13) && bt[c]) m_pc[c] = m_opnd[c];
                            launch(c);
                        end
                    end
                end else begin
                    m_wait[c]--;
                    if (m_wait[c] == 0) m_valid[c] = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("c%0d valid", c), dv[c], m_valid[c]);
                chk($sformatf("c%0d busy", c), busy[c], m_busy[c]);
                chk($sformatf("c%0d halted", c), halted[c], m_halt[c]);
                if (m_valid[c] || !m_busy[c]) chk($sformatf("c%0d addr", c), addr[c], m_pc[c]);
                if (m_valid[c]) begin
                    chk($sformatf("c%0d opcode", c), op[c], m_op[c]);
                    chk($sformatf("c%0d operand", c), opnd[c], m_opnd[c]);
                    chk($sformatf("c%0d has_operand", c), has[c], m_has[c]);
`ifdef IFU_SKIP_COUNT_EN
                    chk($sformatf("c%0d skip_count", c), skc[c], m_skip[c]);
`endif
                end
            end
        end
    end

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 65536; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1;
        @(negedge clock); reset = 0;
    endtask

    task automatic pulse();
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
    endtask

    task automatic wait_valid(input int c, input int bound);
        for (int i = 0; i < bound && !dv[c]; i++) @(negedge clock);
        chk($sformatf("c%0d wait_valid", c), dv[c], 1);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin ready[c] = 1; bt[c] = 0; end
        fill(16'hF02F);
        do_reset();
        chk_en = 1;
        chk("reset valid", dv[0], 0);
        chk("reset addr", addr[0], 0);
        chk("reset busy", busy[0], 0);
        chk("reset halted", halted[0], 0);

        // Core a presents loada with operand; core b skips it and presents opcode 23.
        mem[0] = 16'd4099; mem[1] = 16'd0; mem[2] = 16'd8215;
        pulse();
        repeat (3) @(negedge clock);
        chk("a early valid", dv[0], 0);
        @(negedge clock);
        chk("a first valid", dv[0], 1);
        chk("a opcode", op[0], 3);
        chk("a operand", opnd[0], 0);
        chk("a has_operand", has[0], 1);
        chk("a next addr", addr[0], 2);
        chk("b first valid", dv[1], 1);
        chk("b opcode", op[1], 23);
        chk("b next addr", addr[1], 3);
`ifdef IFU_SKIP_COUNT_EN
        chk("b skip_count", skc[1], 1);
`endif

        // Reset while core a waits for its operand word.
        do_reset();
        pulse();
        repeat (3) @(negedge clock);
        chk("odata busy", busy[0], 1);
        reset = 1;
        @(negedge clock);
        chk("abort valid", dv[0], 0);
        chk("abort busy", busy[0], 0);
        chk("abort addr", addr[0], 0);
        reset = 0;

        // Broadcast word after 63 skipped words.
        fill(16'hF02F);
        for (int i = 0; i < 63; i++) mem[i] = 16'd0;
        mem[63] = 16'd61475;
        do_reset();
        pulse();
        wait_valid(0, 300);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bcast c%0d valid", c), dv[c], 1);
            chk($sformatf("bcast c%0d opcode", c), op[c], 35);
            chk($sformatf("bcast c%0d addr", c), addr[c], 64);
`ifdef IFU_SKIP_COUNT_EN
            chk($sformatf("bcast c%0d skips", c), skc[c], 63);
`endif
        end

        // Jump taken then not taken; stall and halt on the taken path.
        for (int k = 0; k < 2; k++) begin
            fill(16'hF02F);
            for (int i = 0; i < 13; i++) mem[i] = 16'd0;
            mem[13] = 16'd4105; mem[14] = 16'd87; mem[87] = 16'd4144;
            ready[0] = 0;
            do_reset();
            pulse();
            wait_valid(0, 100);
            chk("jump opcode", op[0], 9);
            chk("jump operand", opnd[0], 87);
            chk("jump has_operand", has[0], 1);
            bt[0] = (k == 0); ready[0] = 1;
            @(negedge clock);
            ready[0] = 0; bt[0] = 0;
            chk($sformatf("jump%0d next addr", k), addr[0], (k == 0) ? 87 : 15);
            if (k == 0) begin
                wait_valid(0, 100);
                chk("endop opcode", op[0], 48);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clock);
                    chk("stall valid", dv[0], 1);
                    chk("stall opcode", op[0], 48);
                end
                ready[0] = 1;
                @(negedge clock);
                ready[0] = 0;
                chk("halt halted", halted[0], 1);
                chk("halt busy", busy[0], 0);
                pulse();
                repeat (5) @(negedge clock);
                chk("halt ignores start", halted[0], 1);
                chk("halt stays idle", busy[0], 0);
            end
        end

        // Randomised memory, handshakes, redirects, restarts and resets.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 65536; i++) begin
                int sel;
                logic [11:0] o;
                sel = $urandom_range(0, 63);
                o = sel < 6 ? 12'd3 : sel < 10 ? 12'd9 : sel < 14 ? 12'd13 : sel == 14 ? 12'd48 : 12'($urandom_range(0, 4095));
                mem[i] = {4'($urandom), o};
            end
            for (int c = 0; c < 4; c++) ready[c] = 1;
            do_reset();
            pulse();
            repeat (2500) begin
                @(negedge clock);
                for (int c = 0; c < 4; c++) begin
                    ready[c] = $urandom_range(0, 9) < 7;
                    bt[c]    = 1'($urandom_range(0, 1));
                end
                start = $urandom_range(0, 49) == 0;
                reset = $urandom_range(0, 499) == 0;
            end
            @(negedge clock);
            start = 0; reset = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
